// File: rtl/lcd_pixel_pack_adapter_pkg.sv
// Shared constants for the LCD pixel stream adapters.
// Lane 0 is the most significant symbol of a beat.
package lcd_pixel_pack_adapter_pkg;

   localparam int SYMBOL_W         = 8;
   localparam int SYMBOLS_PER_BEAT = 3;
   localparam int EMPTY_W          = 2;
   localparam int BEAT_W           = SYMBOL_W * SYMBOLS_PER_BEAT;

   typedef logic [1:0] lane_t;

   localparam lane_t LANE0 = 2'd0;
   localparam lane_t LANE1 = 2'd1;
   localparam lane_t LANE2 = 2'd2;

   function automatic int lane_lsb(input lane_t lane);
      return (SYMBOLS_PER_BEAT - 1 - int'(lane)) * SYMBOL_W;
   endfunction

endpackage

// File: rtl/lcd_pixel_pack_adapter.sv
// Packs an 8-bit Avalon-ST symbol stream into 24-bit beats,
// preserving sop/eop and generating empty on short final beats.
module lcd_pixel_pack_adapter
   import lcd_pixel_pack_adapter_pkg::*;
(
   input  logic                clk,
   input  logic                reset_n,
   output logic                in_ready,
   input  logic                in_valid,
   input  logic [SYMBOL_W-1:0] in_data,
   input  logic                in_startofpacket,
   input  logic                in_endofpacket,
   input  logic                out_ready,
   output logic                out_valid,
   output logic [BEAT_W-1:0]   out_data,
   output logic                out_startofpacket,
   output logic                out_endofpacket,
   output logic [EMPTY_W-1:0]  out_empty
);

   lane_t               r_cnt;
   logic [SYMBOL_W-1:0] r_hold0;
   logic [SYMBOL_W-1:0] r_hold1;
   logic                r_hold_sop;

   logic                r_out_valid;
   logic [BEAT_W-1:0]   r_out_data;
   logic                r_out_sop;
   logic                r_out_eop;
   logic [EMPTY_W-1:0]  r_out_empty;

   logic                w_in_ready;
   logic                w_in_xfer;
   lane_t               w_lane;
   logic                w_emit;
   logic [BEAT_W-1:0]   w_held;
   logic [BEAT_W-1:0]   w_sym;
   logic [BEAT_W-1:0]   w_beat;
   logic                w_beat_sop;
   logic [EMPTY_W-1:0]  w_empty;

   assign w_in_ready = out_ready || !r_out_valid;
   assign w_in_xfer  = in_valid && w_in_ready;

   // A sop symbol always restarts at lane 0, dropping any partial beat.
   assign w_lane = in_startofpacket ? LANE0 : r_cnt;
   assign w_emit = w_in_xfer && (in_endofpacket || (w_lane == LANE2));

   always_comb begin
      w_held = '0;
      case (w_lane)
         LANE1:   w_held = {r_hold0, {(2*SYMBOL_W){1'b0}}};
         LANE2:   w_held = {r_hold0, r_hold1, {SYMBOL_W{1'b0}}};
         default: w_held = '0;
      endcase
   end

   assign w_sym      = BEAT_W'(in_data) << lane_lsb(w_lane);
   assign w_beat     = w_held | w_sym;
   assign w_beat_sop = (w_lane == LANE0) ? in_startofpacket : r_hold_sop;
   assign w_empty    = in_endofpacket ? EMPTY_W'(LANE2 - w_lane) : '0;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_cnt      <= LANE0;
         r_hold0    <= '0;
         r_hold1    <= '0;
         r_hold_sop <= 1'b0;
      end else if (w_in_xfer) begin
         if (w_emit) begin
            r_cnt      <= LANE0;
            r_hold_sop <= 1'b0;
         end else begin
            r_cnt <= w_lane + 2'd1;
            if (w_lane == LANE0) begin
               r_hold0    <= in_data;
               r_hold_sop <= in_startofpacket;
            end else begin
               r_hold1 <= in_data;
            end
         end
      end
   end

   // A new beat may replace one leaving in the same cycle.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
         r_out_sop   <= 1'b0;
         r_out_eop   <= 1'b0;
         r_out_empty <= '0;
      end else if (w_emit) begin
         r_out_valid <= 1'b1;
         r_out_data  <= w_beat;
         r_out_sop   <= w_beat_sop;
         r_out_eop   <= in_endofpacket;
         r_out_empty <= w_empty;
      end else if (out_ready) begin
         r_out_valid <= 1'b0;
      end
   end

   assign in_ready          = w_in_ready;
   assign out_valid         = r_out_valid;
   assign out_data          = r_out_data;
   assign out_startofpacket = r_out_sop;
   assign out_endofpacket   = r_out_eop;
   assign out_empty         = r_out_empty;

endmodule
